expr_buffer: RTL and testbench

EXPR_BUFFER -- requirements
Module: expr_buffer

---
 rtl/expr_buffer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_expr_buffer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_buffer.sv
// ---------------------------------------------------------------------------
// expr_buffer
//
// Line-editor style token buffer driven by level-held key commands. Tokens
// live in a fixed array of slots; a cursor (ptr) marks the insertion point.
// Insert places a token at the cursor and shifts the tail right; delete
// removes the token left of the cursor and shifts the tail left. An eval
// command streams the whole buffer out over a valid/ready interface without
// disturbing the stored contents.
//
// Parameters
//   width  token width in bits
//   depth  number of token slots (>= 2)
//
// Ports
//   clock           sole clock, all state changes on the rising edge
//   reset           synchronous active-high reset
//   dataIn          token written by an insert command
//   insert, del_pulse, ptrLeft_pulse, ptrRight_pulse, eval_pulse
//                   level-held command keys, acted on at their rising edge
//   out_data        streamed token
//   out_valid       out_data is valid
//   out_last        marks the final streamed token
//   out_ready       downstream accepts the token when out_valid is high
//   size, ptr       stored token count and cursor position (0..size)
//   full, empty     size == depth, size == 0
//   busy            streaming in progress
//   err             one-cycle pulse when a command is rejected
//   disp_addr       display read address
//   disp_data       combinational read of the slot at disp_addr
// ---------------------------------------------------------------------------
module expr_buffer #(
  parameter int width = 8,
  parameter int depth = 16,
  localparam int PW = $clog2(depth + 1),
  localparam int AW = $clog2(depth)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] dataIn,
  input  logic             insert,
  input  logic             del_pulse,
  input  logic             ptrLeft_pulse,
  input  logic             ptrRight_pulse,
  input  logic             eval_pulse,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [PW-1:0]    size,
  output logic [PW-1:0]    ptr,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             err,
  input  logic [AW-1:0]    disp_addr,
  output logic [width-1:0] disp_data
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Token storage. Every slot can shift in one cycle, so this is a register
  // array rather than a RAM.
  logic [width-1:0] mem [depth];

  state_t           state_reg;
  logic [PW-1:0]    size_reg;
  logic [PW-1:0]    ptr_reg;
  logic [PW-1:0]    rd_reg;
  logic [width-1:0] out_data_reg;
  logic             out_valid_reg;
  logic             out_last_reg;
  logic             busy_reg;
  logic             err_reg;

  // Previous levels of the command keys for rising-edge detection.
  logic insert_prev;
  logic del_prev;
  logic left_prev;
  logic right_prev;
  logic eval_prev;

  logic insert_edge;
  logic del_edge;
  logic left_edge;
  logic right_edge;
  logic eval_edge;

  logic do_eval;
  logic do_delete;
  logic do_insert;
  logic do_left;
  logic do_right;
  logic cmd_err;

  logic          full_int;
  logic          empty_int;
  logic          handshake;
  logic [PW-1:0] rd_next;
  logic [AW-1:0] rd_next_idx;

  assign insert_edge = insert         & ~insert_prev;
  assign del_edge    = del_pulse      & ~del_prev;
  assign left_edge   = ptrLeft_pulse  & ~left_prev;
  assign right_edge  = ptrRight_pulse & ~right_prev;
  assign eval_edge   = eval_pulse     & ~eval_prev;

  assign full_int  = (size_reg == PW'(depth));
  assign empty_int = (size_reg == '0);

  assign handshake   = out_valid_reg & out_ready;
  assign rd_next     = rd_reg + PW'(1);
  assign rd_next_idx = rd_next[AW-1:0];

  // Command arbitration: only the highest-priority edge is considered, and
  // only in IDLE. Lower-priority edges in the same cycle vanish without err.
  always_comb begin
    do_eval   = 1'b0;
    do_delete = 1'b0;
    do_insert = 1'b0;
    do_left   = 1'b0;
    do_right  = 1'b0;
    cmd_err   = 1'b0;
    if (state_reg == IDLE) begin
      if (eval_edge) begin
        if (!empty_int) do_eval = 1'b1;
        else            cmd_err = 1'b1;
      end else if (del_edge) begin
        if (ptr_reg != '0) do_delete = 1'b1;
        else               cmd_err   = 1'b1;
      end else if (insert_edge) begin
        if (!full_int) do_insert = 1'b1;
        else           cmd_err   = 1'b1;
      end else if (left_edge) begin
        if (ptr_reg != '0) do_left = 1'b1;
        else               cmd_err = 1'b1;
      end else if (right_edge) begin
        if (ptr_reg < size_reg) do_right = 1'b1;
        else                    cmd_err  = 1'b1;
      end
    end
  end

  // Per-slot update. Each slot only needs its two neighbours to implement
  // the insert (shift right from ptr) and delete (shift left into ptr-1).
  for (genvar gi = 0; gi < depth; gi++) begin : g_slot
    localparam logic [PW-1:0] IDX = PW'(gi);
    logic [width-1:0] lower;
    logic [width-1:0] upper;

    if (gi > 0) begin : g_lower
      assign lower = mem[gi-1];
    end else begin : g_lower_edge
      assign lower = '0;
    end

    if (gi < depth - 1) begin : g_upper
      assign upper = mem[gi+1];
    end else begin : g_upper_edge
      assign upper = '0;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        mem[gi] <= '0;
      end else if (do_insert) begin
        if (IDX == ptr_reg)
          mem[gi] <= dataIn;
        else if ((IDX > ptr_reg) && (IDX <= size_reg))
          mem[gi] <= lower;
      end else if (do_delete) begin
        // Slots ptr-1 .. size-1 take their right neighbour; the old last
        // slot is cleared so freed slots always read back as zero.
        if (((IDX + PW'(1)) >= ptr_reg) && (IDX < size_reg))
          mem[gi] <= ((IDX + PW'(1)) < size_reg) ? upper : '0;
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clock) begin
    // The key history tracks the live levels even during reset, so a key
    // still held when reset releases does not look like a fresh press.
    insert_prev <= insert;
    del_prev    <= del_pulse;
    left_prev   <= ptrLeft_pulse;
    right_prev  <= ptrRight_pulse;
    eval_prev   <= eval_pulse;

    if (reset) begin
      state_reg     <= IDLE;
      size_reg      <= '0;
      ptr_reg       <= '0;
      rd_reg        <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      err_reg <= cmd_err;
      case (state_reg)
        IDLE: begin
          if (do_eval) begin
            state_reg     <= STREAM;
            busy_reg      <= 1'b1;
            rd_reg        <= '0;
            out_valid_reg <= 1'b1;
            out_data_reg  <= mem[0];
            out_last_reg  <= (size_reg == PW'(1));
          end
          if (do_insert) begin
            size_reg <= size_reg + PW'(1);
            ptr_reg  <= ptr_reg + PW'(1);
          end
          if (do_delete) begin
            size_reg <= size_reg - PW'(1);
            ptr_reg  <= ptr_reg - PW'(1);
          end
          if (do_left)  ptr_reg <= ptr_reg - PW'(1);
          if (do_right) ptr_reg <= ptr_reg + PW'(1);
        end
        STREAM: begin
          // Output registers only move on a handshake, which keeps the
          // token stable while downstream stalls.
          if (handshake) begin
            if (out_last_reg) begin
              state_reg     <= IDLE;
              busy_reg      <= 1'b0;
              rd_reg        <= '0;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              out_data_reg  <= '0;
            end else begin
              rd_reg       <= rd_next;
              out_data_reg <= mem[rd_next_idx];
              out_last_reg <= (rd_next == (size_reg - PW'(1)));
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign size      = size_reg;
  assign ptr       = ptr_reg;
  assign full      = full_int;
  assign empty     = empty_int;
  assign busy      = busy_reg;
  assign err       = err_reg;
  assign disp_data = mem[disp_addr];

endmodule

// File: tb/tb_expr_buffer.sv
// ---------------------------------------------------------------------------
// tb_expr_buffer
//
// Self-checking bench for expr_buffer. A queue plus an integer cursor model
// the buffer; commands are applied as key presses (level high for a number
// of cycles, then low). A table of directed presses with hand-written
// expected size/ptr/err is followed by hand sequences for streaming,
// same-cycle commands and reset corner cases, then randomized presses.
// ---------------------------------------------------------------------------
module tb_expr_buffer;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int PW = $clog2(D + 1);
  localparam int AW = $clog2(D);

  localparam logic [4:0] M_INS   = 5'b00001;
  localparam logic [4:0] M_DEL   = 5'b00010;
  localparam logic [4:0] M_LEFT  = 5'b00100;
  localparam logic [4:0] M_RIGHT = 5'b01000;
  localparam logic [4:0] M_EVAL  = 5'b10000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  dataIn = '0;
  logic          insert = 1'b0;
  logic          del_pulse = 1'b0;
  logic          ptrLeft_pulse = 1'b0;
  logic          ptrRight_pulse = 1'b0;
  logic          eval_pulse = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic [PW-1:0] size;
  logic [PW-1:0] ptr;
  logic          full;
  logic          empty;
  logic          busy;
  logic          err;
  logic [AW-1:0] disp_addr = '0;
  logic [W-1:0]  disp_data;

  expr_buffer #(.width(W), .depth(D)) dut (
    .clock          (clock),
    .reset          (reset),
    .dataIn         (dataIn),
    .insert         (insert),
    .del_pulse      (del_pulse),
    .ptrLeft_pulse  (ptrLeft_pulse),
    .ptrRight_pulse (ptrRight_pulse),
    .eval_pulse     (eval_pulse),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .size           (size),
    .ptr            (ptr),
    .full           (full),
    .empty          (empty),
    .busy           (busy),
    .err            (err),
    .disp_addr      (disp_addr),
    .disp_data      (disp_data)
  );

  always #20 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: token list and cursor.
  logic [7:0] mq[$];
  int         mptr = 0;

  typedef struct {
    logic [4:0] mask;
    logic [7:0] data;
    int         exp_size;
    int         exp_ptr;
    bit         exp_err;
  } vec_t;

  vec_t tbl[14];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] mask);
    {eval_pulse, ptrRight_pulse, ptrLeft_pulse, del_pulse, insert} = mask;
  endtask

  // Behavioural command semantics: highest-priority key decides, the rest
  // of the keys pressed in the same cycle are ignored.
  task automatic model_cmd(input logic [4:0] mask, input logic [7:0] data,
                           output bit e, output bit st);
    e  = 1'b0;
    st = 1'b0;
    if (mask[4]) begin
      if (mq.size() == 0) e = 1'b1;
      else                st = 1'b1;
    end else if (mask[1]) begin
      if (mptr == 0) e = 1'b1;
      else begin
        mq.delete(mptr - 1);
        mptr--;
      end
    end else if (mask[0]) begin
      if (mq.size() == D) e = 1'b1;
      else begin
        mq.insert(mptr, data);
        mptr++;
      end
    end else if (mask[2]) begin
      if (mptr == 0) e = 1'b1;
      else           mptr--;
    end else if (mask[3]) begin
      if (mptr >= mq.size()) e = 1'b1;
      else                   mptr++;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_size"},  size,  mq.size());
    chk({tag, "_ptr"},   ptr,   mptr);
    chk({tag, "_full"},  full,  mq.size() == D);
    chk({tag, "_empty"}, empty, mq.size() == 0);
    for (int a = 0; a < D; a++) begin
      disp_addr = a[AW-1:0];
      #1;
      chk({tag, "_slot"}, disp_data, (a < mq.size()) ? mq[a] : 8'h00);
    end
  endtask

  // Streams the buffer and checks every token against the model. With hand
  // set, out_ready follows 1,0,1,1 then stays high; with inject set an
  // insert key is pressed during the stream and must be ignored.
  task automatic run_stream(input bit hand, input bit inject);
    int         idx = 0;
    int         cyc = 0;
    int         n   = mq.size();
    bit         r;
    logic [3:0] pat = 4'b1101;
    while (idx < n && cyc < 200) begin
      chk("stream_valid", out_valid, 1);
      chk("stream_data",  out_data,  mq[idx]);
      chk("stream_last",  out_last,  idx == n - 1);
      chk("stream_busy",  busy,      1);
      if (hand) r = (cyc < 4) ? pat[cyc] : 1'b1;
      else      r = 1'($urandom_range(0, 1));
      out_ready = r;
      if (inject) insert = (cyc == 1);
      tick();
      cyc++;
      if (r) idx++;
    end
    out_ready = 1'b0;
    insert    = 1'b0;
    if (idx < n) begin
      n_vec++;
      n_err++;
      $display("FAIL stream_timeout: got %0d tokens expected %0d", idx, n);
    end
    chk("stream_end_valid", out_valid, 0);
    chk("stream_end_busy",  busy,      0);
    chk("stream_end_last",  out_last,  0);
    $display("stream: %0d tokens in %0d cycles", n, cyc);
  endtask

  // One key press: keys high for hold cycles, then all low for one cycle.
  task automatic press(input logic [4:0] mask, input logic [7:0] data, input int hold,
                       input bit auto_stream, output bit seen_err);
    bit e;
    bit st;
    model_cmd(mask, data, e, st);
    dataIn = data;
    drive(mask);
    tick();
    seen_err = err;
    chk("cmd_err",  err,  e);
    chk("cmd_size", size, mq.size());
    chk("cmd_ptr",  ptr,  mptr);
    chk("cmd_valid", out_valid, st);
    if (st) chk("cmd_first", out_data, mq[0]);
    for (int i = 1; i < hold; i++) begin
      tick();
      chk("err_once", err, 0);
    end
    drive(5'b0);
    tick();
    chk("err_clear", err, 0);
    check_state("cmd");
    $display("press mask=%b data=%h -> size=%0d ptr=%0d err=%0b", mask, data, size, ptr, seen_err);
    if (st && auto_stream) run_stream(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mq.delete();
    mptr = 0;
    tick();
  endtask

  task automatic chk_slot(input int a, input logic [7:0] exp);
    disp_addr = a[AW-1:0];
    #1;
    chk("const_slot", disp_data, exp);
  endtask

  initial begin
    bit       se;
    int       c;
    logic [4:0] m;

    tbl[0]  = '{M_INS,   8'h01, 1, 1, 1'b0};
    tbl[1]  = '{M_INS,   8'h02, 2, 2, 1'b0};
    tbl[2]  = '{M_INS,   8'h03, 3, 3, 1'b0};
    tbl[3]  = '{M_LEFT,  8'h00, 3, 2, 1'b0};
    tbl[4]  = '{M_INS,   8'hA0, 4, 3, 1'b0};
    tbl[5]  = '{M_DEL,   8'h00, 3, 2, 1'b0};
    tbl[6]  = '{M_LEFT,  8'h00, 3, 1, 1'b0};
    tbl[7]  = '{M_LEFT,  8'h00, 3, 0, 1'b0};
    tbl[8]  = '{M_LEFT,  8'h00, 3, 0, 1'b1};
    tbl[9]  = '{M_DEL,   8'h00, 3, 0, 1'b1};
    tbl[10] = '{M_RIGHT, 8'h00, 3, 1, 1'b0};
    tbl[11] = '{M_RIGHT, 8'h00, 3, 2, 1'b0};
    tbl[12] = '{M_RIGHT, 8'h00, 3, 3, 1'b0};
    tbl[13] = '{M_RIGHT, 8'h00, 3, 3, 1'b1};

    // Insert key held through reset release must not insert.
    insert = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_size", size, 0);
      chk("held_err",  err,  0);
    end
    insert = 1'b0;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_last",  out_last,  0);
    chk("rst_busy",  busy,      0);
    chk("rst_data",  out_data,  0);
    check_state("reset");
    press(M_INS, 8'h55, 1, 1'b1, se);
    chk("repress_size", size, 1);

    // Directed table.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      press(tbl[i].mask, tbl[i].data, 3, 1'b1, se);
      chk("tbl_size", size, tbl[i].exp_size);
      chk("tbl_ptr",  ptr,  tbl[i].exp_ptr);
      chk("tbl_err",  se,   tbl[i].exp_err);
      if (i == 4) begin
        chk_slot(0, 8'h01); chk_slot(1, 8'h02); chk_slot(2, 8'hA0); chk_slot(3, 8'h03);
      end
      if (i == 5) begin
        chk_slot(0, 8'h01); chk_slot(1, 8'h02); chk_slot(2, 8'h03); chk_slot(3, 8'h00);
      end
    end

    // Eval on an empty buffer.
    do_reset();
    press(M_EVAL, 8'h00, 1, 1'b1, se);
    chk("eval_empty_err", se, 1);

    // Fill to capacity, then one more.
    for (int i = 0; i < D; i++) press(M_INS, 8'($urandom_range(0, 255)), 1, 1'b1, se);
    chk("full_flag", full, 1);
    press(M_INS, 8'hEE, 1, 1'b1, se);
    chk("overflow_err",  se,   1);
    chk("overflow_size", size, D);

    // Stream 5, A0, 7 with stalls and an insert press mid-stream.
    do_reset();
    press(M_INS, 8'h05, 1, 1'b1, se);
    press(M_INS, 8'hA0, 1, 1'b1, se);
    press(M_INS, 8'h07, 1, 1'b1, se);
    press(M_EVAL, 8'h00, 1, 1'b0, se);
    run_stream(1'b1, 1'b1);
    check_state("after_stream");
    chk("after_stream_size", size, 3);

    // Insert and delete pressed together at ptr=2: only delete runs.
    press(M_LEFT, 8'h00, 1, 1'b1, se);
    press(M_INS | M_DEL, 8'h99, 1, 1'b1, se);
    chk("both_size", size, 2);
    chk("both_ptr",  ptr,  1);
    chk_slot(0, 8'h05);
    chk_slot(1, 8'h07);

    // Reset in the middle of a stream.
    press(M_EVAL, 8'h00, 1, 1'b0, se);
    reset = 1'b1;
    tick();
    chk("abort_valid", out_valid, 0);
    chk("abort_busy",  busy,      0);
    reset = 1'b0;
    mq.delete();
    mptr = 0;
    tick();
    check_state("abort");

    // Randomized presses against the model.
    for (int k = 0; k < 300; k++) begin
      c = $urandom_range(0, 9);
      if (c <= 3)      m = M_INS;
      else if (c <= 5) m = M_DEL;
      else if (c == 6) m = M_LEFT;
      else if (c == 7) m = M_RIGHT;
      else if (c == 8) m = M_EVAL;
      else             m = 5'($urandom_range(1, 31));
      press(m, 8'($urandom_range(0, 255)), $urandom_range(1, 3), 1'b1, se);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
